sram_controller: RTL and testbench

Bridges the pipeline's Memory stage to a 256K×16 asynchronous SRAM. Each 32-bit word access from the Memory stage becomes two 16-bit SRAM cycles: low half first, then high half. The controller holds the pipeline with `mem_mc_stall` until the word is complete. On a read it returns the assembled word on the shared `mem_mc_data` bus for exactly one cycle, and the Memory stage samples it at the next clock edge.

---
 rtl/sram_controller.sv | 136 +++++++++++++
 tb/tb_sram_controller.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Memory-stage to 256Kx16 async SRAM bridge: each 32-bit word becomes two
// 16-bit SRAM cycles (low half, then high half). The pipeline is stalled until the word completes.
module sram_controller (
    input  logic        clock,
    input  logic        reset,
    input  logic        mem_mc_en,
    input  logic        mem_mc_rw,
    input  logic [17:0] mem_mc_addr,
    inout  wire  [31:0] mem_mc_data,
    output logic        mem_mc_stall,
    output logic [17:0] sram_addr,
    inout  wire  [15:0] sram_data,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n
);

    typedef enum logic [2:0] {
        IDLE,
        LO_SETUP,
        LO_STB,
        HI_SETUP,
        HI_STB,
        DONE
    } state_t;

    state_t      state;
    state_t      next_state;
    logic        rw_q;
    logic [16:0] addr_q;
    logic [31:0] wdata;
    logic [31:0] rdata;

    logic        eff_rw;
    logic [16:0] eff_addr;
    logic [17:0] next_sram_addr;
    logic        next_ce_n;
    logic        next_oe_n;
    logic        next_we_n;
    logic        in_lo;
    logic        in_hi;
    logic        unused_addr_msb;

    assign unused_addr_msb = mem_mc_addr[17];

    assign in_lo = (state == LO_SETUP) || (state == LO_STB);
    assign in_hi = (state == HI_SETUP) || (state == HI_STB);

    assign mem_mc_stall = ((state == IDLE) && mem_mc_en) || in_lo || in_hi;

    assign sram_data   = (rw_q && in_lo) ? wdata[15:0]  :
                         (rw_q && in_hi) ? wdata[31:16] : 16'bz;
    assign mem_mc_data = ((state == DONE) && !rw_q) ? rdata : 32'bz;

    // The strobes share one enable: both byte lanes are always used together.
    assign sram_ub_n = sram_ce_n;
    assign sram_lb_n = sram_ce_n;

    always_comb begin
        next_state = state;
        case (state)
            IDLE:     if (mem_mc_en) next_state = LO_SETUP;
            LO_SETUP: next_state = LO_STB;
            LO_STB:   next_state = HI_SETUP;
            HI_SETUP: next_state = HI_STB;
            HI_STB:   next_state = DONE;
            DONE:     next_state = IDLE;
            default:  next_state = IDLE;
        endcase
    end

    // Strobes are registered on the state being entered; in IDLE the request
    // has not been captured yet, so the live inputs supply rw and address.
    always_comb begin
        eff_rw         = (state == IDLE) ? mem_mc_rw : rw_q;
        eff_addr       = (state == IDLE) ? mem_mc_addr[16:0] : addr_q;
        next_sram_addr = sram_addr;
        next_ce_n      = 1'b1;
        next_oe_n      = 1'b1;
        next_we_n      = 1'b1;
        case (next_state)
            LO_SETUP, LO_STB: begin
                next_sram_addr = {eff_addr, 1'b0};
                next_ce_n      = 1'b0;
                next_oe_n      = eff_rw;
                next_we_n      = !(eff_rw && (next_state == LO_STB));
            end
            HI_SETUP, HI_STB: begin
                next_sram_addr = {eff_addr, 1'b1};
                next_ce_n      = 1'b0;
                next_oe_n      = eff_rw;
                next_we_n      = !(eff_rw && (next_state == HI_STB));
            end
            default: begin
                next_ce_n = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            sram_addr <= '0;
            sram_ce_n <= 1'b1;
            sram_oe_n <= 1'b1;
            sram_we_n <= 1'b1;
        end else begin
            state     <= next_state;
            sram_addr <= next_sram_addr;
            sram_ce_n <= next_ce_n;
            sram_oe_n <= next_oe_n;
            sram_we_n <= next_we_n;
        end
    end

    // Request capture and read-data assembly; halves are taken as each strobe ends.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rw_q   <= 1'b0;
            addr_q <= '0;
            wdata  <= '0;
            rdata  <= '0;
        end else begin
            if ((state == IDLE) && mem_mc_en) begin
                rw_q   <= mem_mc_rw;
                addr_q <= mem_mc_addr[16:0];
                wdata  <= mem_mc_data;
            end
            if ((state == LO_STB) && !rw_q) rdata[15:0]  <= sram_data;
            if ((state == HI_STB) && !rw_q) rdata[31:16] <= sram_data;
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: behavioural SRAM, word-level
// reference memory, table vectors, randomized accesses and corner sequences.
module tb_sram_controller;

    logic        clock = 1'b0;
    logic        reset;
    logic        mem_mc_en;
    logic        mem_mc_rw;
    logic [17:0] mem_mc_addr;
    wire  [31:0] mem_mc_data;
    logic        mem_mc_stall;
    logic [17:0] sram_addr;
    wire  [15:0] sram_data;
    logic        sram_ce_n;
    logic        sram_oe_n;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;

    logic        tb_drive;
    logic [31:0] tb_wdata;
    logic [15:0] sram_mem [0:262143];
    logic [17:0] max_sram_addr = '0;

    bit   [31:0] ref_mem [int];
    logic [16:0] written_q [$];

    int n_vec = 0;
    int n_err = 0;

    localparam logic [31:0] BUS_Z  = 32'hFFFF_FFFF;
    localparam logic [15:0] HALF_Z = 16'hFFFF;

    typedef struct {
        bit          rw;
        logic [17:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    sram_controller dut (
        .clock        (clock),
        .reset        (reset),
        .mem_mc_en    (mem_mc_en),
        .mem_mc_rw    (mem_mc_rw),
        .mem_mc_addr  (mem_mc_addr),
        .mem_mc_data  (mem_mc_data),
        .mem_mc_stall (mem_mc_stall),
        .sram_addr    (sram_addr),
        .sram_data    (sram_data),
        .sram_ce_n    (sram_ce_n),
        .sram_oe_n    (sram_oe_n),
        .sram_we_n    (sram_we_n),
        .sram_ub_n    (sram_ub_n),
        .sram_lb_n    (sram_lb_n)
    );

    // Released buses float high so Z is observable as all-ones.
    pullup (mem_mc_data);
    pullup (sram_data);

    assign mem_mc_data = tb_drive ? tb_wdata : 32'bz;
    assign sram_data   = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr] : 16'bz;

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (!sram_ce_n && !sram_we_n) sram_mem[sram_addr] <= sram_data;
        if (!sram_ce_n && (sram_addr > max_sram_addr)) max_sram_addr <= sram_addr;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got timeout expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic apply_stimulus(input bit rw, input logic [17:0] addr, input logic [31:0] data);
        mem_mc_en   = 1'b1;
        mem_mc_rw   = rw;
        mem_mc_addr = addr;
        tb_wdata    = data;
        tb_drive    = rw;
        #1;
    endtask

    // Counts stalled cycles from the current one and returns in the first non-stalled cycle.
    task automatic finish_access(input string tag, output logic [31:0] rd, output int stalls);
        logic leak;
        leak   = 1'b0;
        stalls = 0;
        while (mem_mc_stall && stalls < 12) begin
            stalls++;
            if (!tb_drive && (mem_mc_data !== BUS_Z)) leak = 1'b1;
            @(negedge clock);
            mem_mc_en = 1'b0;
            tb_drive  = 1'b0;
            #1;
        end
        rd = mem_mc_data;
        check_output({tag, " bus_z_before_done"}, {31'b0, leak}, 32'd0);
    endtask

    task automatic do_access(input string tag, input bit rw, input logic [17:0] addr,
                             input logic [31:0] data, input logic [31:0] exp_rd);
        logic [31:0] rd;
        int          stalls;
        apply_stimulus(rw, addr, data);
        finish_access(tag, rd, stalls);
        check_output({tag, " stall_cycles"}, stalls, 32'd5);
        check_output({tag, " done_data"}, rd, rw ? BUS_Z : exp_rd);
        @(negedge clock);
        #1;
        check_output({tag, " data_z_after"}, mem_mc_data, BUS_Z);
        if (rw) begin
            ref_mem[int'(addr[16:0])] = data;
            written_q.push_back(addr[16:0]);
        end
    endtask

    task automatic step;
        @(negedge clock);
        #1;
    endtask

    initial begin
        vec_t        vecs [6];
        logic [31:0] rd;
        int          stalls;
        bit          rw;
        logic [16:0] key;
        logic [17:0] addr;
        logic [31:0] data;

        vecs[0] = '{1'b1, 18'h00005, 32'hDEAD_BEEF, 32'h0};
        vecs[1] = '{1'b0, 18'h00005, 32'h0,         32'hDEAD_BEEF};
        vecs[2] = '{1'b1, 18'h20003, 32'hA5A5_0F0F, 32'h0};
        vecs[3] = '{1'b0, 18'h00003, 32'h0,         32'hA5A5_0F0F};
        vecs[4] = '{1'b1, 18'h00000, 32'h0000_0001, 32'h0};
        vecs[5] = '{1'b0, 18'h20000, 32'h0,         32'h0000_0001};

        reset       = 1'b0;
        mem_mc_en   = 1'b0;
        mem_mc_rw   = 1'b0;
        mem_mc_addr = '0;
        tb_drive    = 1'b0;
        tb_wdata    = '0;
        repeat (2) @(negedge clock);
        #1;
        check_output("reset strobes", {27'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check_output("reset sram_addr", {14'b0, sram_addr}, 32'h0);
        check_output("reset data_z", mem_mc_data, BUS_Z);
        mem_mc_en = 1'b1;
        #1;
        check_output("reset stall_follows_en", {31'b0, mem_mc_stall}, 32'd1);
        mem_mc_en = 1'b0;
        @(negedge clock);
        reset = 1'b1;
        step();

        for (int i = 0; i < 6; i++) begin
            do_access($sformatf("vec%0d", i), vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].exp_rd);
        end
        check_output("sram halfword 0x0000A", {16'b0, sram_mem[18'h0000A]}, 32'h0000_BEEF);
        check_output("sram halfword 0x0000B", {16'b0, sram_mem[18'h0000B]}, 32'h0000_DEAD);

        for (int i = 0; i < 40; i++) begin
            rw = (written_q.size() == 0) ? 1'b1 : 1'($urandom_range(0, 1));
            if (rw) begin
                addr = 18'($urandom_range(0, 262143));
                data = $urandom;
                do_access($sformatf("rand%0d wr", i), 1'b1, addr, data, 32'h0);
            end else begin
                key  = written_q[$urandom_range(0, written_q.size() - 1)];
                addr = {1'($urandom_range(0, 1)), key};
                do_access($sformatf("rand%0d rd", i), 1'b0, addr, 32'h0, ref_mem[int'(key)]);
            end
        end

        // Back-to-back: read request already pending while the write sits in DONE.
        max_sram_addr = '0;
        apply_stimulus(1'b1, 18'h1FFFF, 32'h1234_5678);
        finish_access("b2b wr", rd, stalls);
        check_output("b2b wr stall_cycles", stalls, 32'd5);
        check_output("b2b wr done_data_z", rd, BUS_Z);
        apply_stimulus(1'b0, 18'h1FFFF, 32'h0);
        check_output("b2b done_stall_low", {31'b0, mem_mc_stall}, 32'd0);
        step();
        finish_access("b2b rd", rd, stalls);
        check_output("b2b rd stall_cycles", stalls, 32'd5);
        check_output("b2b rd done_data", rd, 32'h1234_5678);
        check_output("b2b max sram_addr", {14'b0, max_sram_addr}, 32'h0003_FFFF);
        step();
        ref_mem[int'(17'h1FFFF)] = 32'h1234_5678;

        // Inputs changed during HI_SETUP must not redirect the access.
        do_access("chg pre", 1'b1, 18'h00050, 32'h1111_1111, 32'h0);
        apply_stimulus(1'b1, 18'h00040, 32'h0BAD_CAFE);
        step();
        mem_mc_en = 1'b0;
        tb_drive  = 1'b0;
        step();
        step();
        mem_mc_addr = 18'h00050;
        mem_mc_rw   = 1'b0;
        #1;
        check_output("chg stall hi_setup", {31'b0, mem_mc_stall}, 32'd1);
        step();
        check_output("chg stall hi_stb", {31'b0, mem_mc_stall}, 32'd1);
        step();
        check_output("chg stall done", {31'b0, mem_mc_stall}, 32'd0);
        step();
        check_output("chg sram lo", {16'b0, sram_mem[18'h00080]}, 32'h0000_CAFE);
        check_output("chg sram hi", {16'b0, sram_mem[18'h00081]}, 32'h0000_0BAD);
        do_access("chg rd orig", 1'b0, 18'h00040, 32'h0, 32'h0BAD_CAFE);
        do_access("chg rd other", 1'b0, 18'h00050, 32'h0, 32'h1111_1111);

        // Reset asserted in LO_STB of a write.
        apply_stimulus(1'b1, 18'h00100, 32'hCAFE_F00D);
        step();
        mem_mc_en = 1'b0;
        tb_drive  = 1'b0;
        step();
        check_output("rst mid we_low", {31'b0, sram_we_n}, 32'd0);
        check_output("rst mid bus_driven", {16'b0, sram_data}, 32'h0000_F00D);
        mem_mc_en = 1'b1;
        reset     = 1'b0;
        #1;
        check_output("rst mid strobes", {27'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check_output("rst mid sram_z", {16'b0, sram_data}, {16'b0, HALF_Z});
        check_output("rst mid sram_addr", {14'b0, sram_addr}, 32'h0);
        check_output("rst mid stall_en", {31'b0, mem_mc_stall}, 32'd1);
        mem_mc_en = 1'b0;
        #1;
        check_output("rst mid stall_noen", {31'b0, mem_mc_stall}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        step();
        step();
        check_output("rst after strobes", {27'b0, sram_ce_n, sram_oe_n, sram_we_n, sram_ub_n, sram_lb_n}, 32'h1F);
        check_output("rst after stall", {31'b0, mem_mc_stall}, 32'd0);
        do_access("rst after rd", 1'b0, 18'h00005, 32'h0, 32'hDEAD_BEEF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
